// File: rtl/armleocpu_ptw_param.sv
// Parametrised RISC-V page table walker (SV32/SV39). Fetches PTEs over single-beat
// AXI reads, walks up to LEVELS levels and returns a 4K PPN with superpages expanded.
`timescale 1ns/1ps

module armleocpu_ptw_param #(
  parameter int LEVELS   = 2,
  parameter int VPN_W    = 10,
  parameter int PPN_W    = 22,
  parameter int PTE_W    = 32,
  parameter int PADDR_W  = 34,
  parameter bit CHECK_AD = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,

  output logic                      axi_arvalid_o,
  input  logic                      axi_arready_i,
  output logic [PADDR_W-1:0]        axi_araddr_o,
  input  logic                      axi_rvalid_i,
  output logic                      axi_rready_o,
  input  logic [1:0]                axi_rresp_i,
  input  logic                      axi_rlast_i,
  input  logic [PTE_W-1:0]          axi_rdata_i,

  input  logic                      resolve_request_i,
  input  logic [1:0]                resolve_access_i,
  input  logic [LEVELS*VPN_W-1:0]   virtual_address_i,
  input  logic [PPN_W-1:0]          satp_ppn_i,
  output logic                      resolve_done_o,
  output logic                      resolve_pagefault_o,
  output logic                      resolve_accessfault_o,
  output logic [7:0]                resolve_metadata_o,
  output logic [PPN_W-1:0]          resolve_physical_address_o
);

  localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int VA_W  = LEVELS * VPN_W;
  localparam int OFF_W = PADDR_W - PPN_W - VPN_W;
  localparam logic [1:0] ACC_STORE = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WALK
  } state_e;

  state_e             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PPN_W-1:0]   table_base_q, table_base_d;
  logic [VA_W-1:0]    vpn_q, vpn_d;
  logic [1:0]         access_q, access_d;
  logic [PTE_W-1:0]   pte_q, pte_d;
  logic               rerr_q, rerr_d;
  logic               done_q, done_d;
  logic               pagefault_q, pagefault_d;
  logic               accessfault_q, accessfault_d;

  logic               pte_v, pte_r, pte_w, pte_x, pte_a, pte_d_bit;
  logic [PPN_W-1:0]   pte_ppn;
  logic [PPN_W-1:0]   low_mask;
  logic               misaligned;
  logic               ad_fault;
  logic               pte_unused;

  assign pte_v     = pte_q[0];
  assign pte_r     = pte_q[1];
  assign pte_w     = pte_q[2];
  assign pte_x     = pte_q[3];
  assign pte_a     = pte_q[6];
  assign pte_d_bit = pte_q[7];
  assign pte_ppn   = pte_q[10 +: PPN_W];
  // RSW and reserved PTE bits are stored but never interpreted.
  assign pte_unused = ^pte_q;

  // Bits of the PPN that a superpage at the current level must leave zero and
  // that the walker fills from the virtual address instead.
  assign low_mask   = ~({PPN_W{1'b1}} << (32'(level_q) * VPN_W));
  assign misaligned = |(pte_ppn & low_mask);
  assign ad_fault   = CHECK_AD && (!pte_a || (access_q == ACC_STORE && !pte_d_bit));

  assign axi_araddr_o = {table_base_q, vpn_q[32'(level_q) * VPN_W +: VPN_W], {OFF_W{1'b0}}};

  assign resolve_done_o             = done_q;
  assign resolve_pagefault_o        = pagefault_q;
  assign resolve_accessfault_o      = accessfault_q;
  assign resolve_metadata_o         = pte_q[7:0];
  assign resolve_physical_address_o = (pte_ppn & ~low_mask) | (PPN_W'(vpn_q) & low_mask);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d       = state_q;
    level_d       = level_q;
    table_base_d  = table_base_q;
    vpn_d         = vpn_q;
    access_d      = access_q;
    pte_d         = pte_q;
    rerr_d        = rerr_q;
    done_d        = 1'b0;
    pagefault_d   = 1'b0;
    accessfault_d = 1'b0;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        vpn_d        = virtual_address_i;
        access_d     = resolve_access_i;
        table_base_d = satp_ppn_i;
        level_d      = LVL_W'(LEVELS - 1);
        if (resolve_request_i) begin
          state_d = S_AR;
        end
      end

      S_AR: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) begin
          state_d = S_R;
        end
      end

      S_R: begin
        axi_rready_o = axi_rvalid_i;
        if (axi_rvalid_i) begin
          pte_d   = axi_rdata_i;
          rerr_d  = (axi_rresp_i != 2'b00);
          state_d = S_WALK;
        end
      end

      S_WALK: begin
        if (rerr_q) begin
          accessfault_d = 1'b1;
          done_d        = 1'b1;
        end else if (!pte_v || (pte_w && !pte_r)) begin
          pagefault_d = 1'b1;
          done_d      = 1'b1;
        end else if (pte_r || pte_x) begin
          // misaligned is always 0 at level 0 because low_mask is empty there.
          pagefault_d = misaligned || ad_fault;
          done_d      = 1'b1;
        end else if (pte_q[7:4] == 4'b0000 && level_q != '0) begin
          level_d      = level_q - LVL_W'(1);
          table_base_d = pte_ppn;
          state_d      = S_AR;
        end else begin
          // Pointer at the last level, or a non-leaf with U/G/A/D set.
          pagefault_d = 1'b1;
          done_d      = 1'b1;
        end
        if (done_d) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      level_q       <= LVL_W'(LEVELS - 1);
      table_base_q  <= '0;
      vpn_q         <= '0;
      access_q      <= '0;
      pte_q         <= '0;
      rerr_q        <= 1'b0;
      done_q        <= 1'b0;
      pagefault_q   <= 1'b0;
      accessfault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      table_base_q  <= table_base_d;
      vpn_q         <= vpn_d;
      access_q      <= access_d;
      pte_q         <= pte_d;
      rerr_q        <= rerr_d;
      done_q        <= done_d;
      pagefault_q   <= pagefault_d;
      accessfault_q <= accessfault_d;
    end
  end

  rlast_every_beat: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_R && axi_rvalid_i) |-> axi_rlast_i);

endmodule

// File: doc/armleocpu_ptw_param.md
Name: armleocpu_ptw_param

Overview:
Parametrised RISC-V page table walker, successor of the fixed SV32 walker; supports SV32 (2 levels, 32-bit PTE) and SV39 (3 levels, 64-bit PTE) via parameters. It issues single-beat AXI read bursts to fetch PTEs, walks up to LEVELS levels, and always returns a 4K-page PPN, expanding superpages. It adds optional hardware A/D checking with an access-type input; faults are reported instead of updating A/D. It sits between the TLB-miss logic of the fetch/LSU and the AXI read interconnect.

Parameters:
LEVELS, 2, number of translation levels (2 = SV32, 3 = SV39)
VPN_W, 10, bits per VPN slice (10 for SV32, 9 for SV39)
PPN_W, 22, physical page number width (22 for SV32, 44 for SV39)
PTE_W, 32, PTE and AXI data width (32 or 64)
PADDR_W, 34, physical address width; must equal PPN_W+VPN_W+log2(PTE_W/8)
CHECK_AD, 1, 1 = pagefault on A=0, or on D=0 for a store; 0 = ignore A/D

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
axi_arvalid  out  1  PTE read address valid
axi_arready  in  1  address accepted
axi_araddr  out  PADDR_W  PTE address
axi_rvalid  in  1  read data valid
axi_rready  out  1  read data accept
axi_rresp  in  2  response; nonzero = error
axi_rlast  in  1  must be 1 on every beat
axi_rdata  in  PTE_W  PTE value
resolve_request  in  1  start walk; sampled only in IDLE
resolve_access  in  2  0 = load, 1 = store, 2 = execute; captured with the request
virtual_address  in  LEVELS*VPN_W  VPN, captured in IDLE
satp_ppn  in  PPN_W  root table PPN; SATP mode is nonbare, otherwise the walker is not used
resolve_done  out  1  one-cycle completion pulse
resolve_pagefault  out  1  valid with done
resolve_accessfault  out  1  valid with done
resolve_metadata  out  8  PTE[7:0] (V R W X U G A D)
resolve_physical_address  out  PPN_W  resolved 4K PPN

Behaviour:
- States: IDLE, AR, R, WALK.
- Reset: state is IDLE, level is LEVELS-1. arvalid, rready, done, pagefault and accessfault are 0. Reset mid-walk abandons the walk with no done pulse.
- IDLE: continuously capture VA, access type and satp_ppn into the table base; level = LEVELS-1. On resolve_request go to AR.
- AR: arvalid=1; araddr = {table_base, vpn[level], zeros}. Move to R when arready is high; araddr stays stable while arvalid is high.
- R: rready=1 only together with rvalid. Latch rdata into the PTE register and record rresp!=0 as the access-error flag; go to WALK. rlast=0 is a protocol error: simulation assertion only, no functional change.
- WALK: evaluate in this priority order:
  1. Access error: accessfault and done.
  2. V=0, or W=1 with R=0: pagefault and done.
  3. Leaf (R or X set):
     - level>0 and PTE PPN[level*VPN_W-1:0]!=0 (misaligned superpage): pagefault.
     - CHECK_AD and (A=0, or store with D=0): pagefault.
     - Otherwise success.
     - All three cases assert done.
  4. Pointer (PTE[3:0]=0001): at level 0, pagefault and done; otherwise level-1, table_base = PTE PPN, go to AR.
  5. Any other encoding (e.g. V=1, R=W=X=0, U/G/A/D set): pagefault and done.
- Any done returns to IDLE.
- PTE PPN = PTE[10 +: PPN_W].
- resolve_physical_address: upper bits from the PTE PPN; the low level*VPN_W bits are taken from the VA's vpn[level-1:0].
- resolve_metadata and resolve_physical_address are driven combinationally from registers and are meaningful only while done=1.
- Done is a single-cycle pulse. A new request is accepted in the IDLE cycle immediately after done.
- Minimum latency with arready and rvalid both high immediately: done in the 4th cycle after the request cycle; each extra level adds 3 cycles.
- resolve_request outside IDLE is ignored.

Test Plan:
- SV32 two-level success: satp_ppn=0x00100, VA=0x00402, load.
  - araddr 0x00100004, rdata 0x00200001 (pointer) -> araddr 0x00800008.
  - rdata 0x123450CF -> done, no faults, phys 0x048D14, metadata 0xCF.
- Megapage: level-1 rdata 0x100000CF, VA vpn0=0x002 -> phys 0x040002, done after one fetch. rdata 0x100004CF -> pagefault (misaligned).
- A/D with CHECK_AD=1:
  - leaf 0x1234500F, load -> pagefault (A=0).
  - leaf 0x1234504F, store -> pagefault (D=0).
  - leaf 0x1234504F, load -> success.
  - With CHECK_AD=0, all three succeed.
- Errors:
  - rresp=2 at level 1 -> accessfault, no second AR.
  - rdata 0x00000000 -> pagefault.
  - Pointer 0x00200001 at level 0 -> pagefault.
- SV39 (LEVELS=3, VPN_W=9, PPN_W=44, PTE_W=64, PADDR_W=56): three pointer/leaf fetches.
  - araddr low 3 bits are 0.
  - A level-2 leaf with PPN[17:0]=0 yields phys PPN high bits from the PTE and low 18 bits from the VA.
- Backpressure and reset:
  - arready held low 5 cycles keeps arvalid and araddr stable.
  - rst_n low during R returns to IDLE with no done pulse.
  - A request in the cycle after done is accepted.
